// File: rtl/ex_mem_stage.sv
// Execute stage + EX/MEM register: ALU, dest select, branch/jump resolve, redirect.
// Latency: 1 cycle EX inputs -> EXMEM outputs; redirect is combinational same cycle.
// Backpressure: EXMEM_WriteEn=0 holds every register and gates redirect; EXMEM_Flush inserts a bubble.
// Optional operand forwarding muxes and ports are enabled by defining EX_FORWARD_EN.
module ex_mem_stage #(
   parameter int WIDTH = 32,
   parameter int REGW  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] EX_InPC,
   input  logic [WIDTH-1:0] EX_InReadData1,
   input  logic [WIDTH-1:0] EX_InReadData2,
   input  logic [WIDTH-1:0] EX_InImm32,
   input  logic [REGW-1:0]  EX_InRt,
   input  logic [REGW-1:0]  EX_InRd,
   input  logic             EX_InALUSrc,
   input  logic             EX_InRegDst,
   input  logic             EX_InJump,
   input  logic             EX_InBranch,
   input  logic [2:0]       EX_InALUCtrl,
   input  logic             EX_InMemWrite,
   input  logic             EX_InMemRead,
   input  logic             EX_InMemtoReg,
   input  logic             EX_InRegWrite,
`ifdef EX_FORWARD_EN
   input  logic [1:0]       EX_ForwardA,
   input  logic [1:0]       EX_ForwardB,
   input  logic [WIDTH-1:0] EX_InWBData,
`endif
   input  logic             EXMEM_WriteEn,
   input  logic             EXMEM_Flush,
   output logic [WIDTH-1:0] EXMEM_OutALUResult,
   output logic [WIDTH-1:0] EXMEM_OutWriteData,
   output logic [REGW-1:0]  EXMEM_OutWriteReg,
   output logic             EXMEM_OutMemWrite,
   output logic             EXMEM_OutMemRead,
   output logic             EXMEM_OutMemtoReg,
   output logic             EXMEM_OutRegWrite,
   output logic             EXMEM_OutValid,
   output logic             EX_Redirect,
   output logic [WIDTH-1:0] EX_RedirectPC
);

   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic [WIDTH-1:0] aluB;
   logic [WIDTH-1:0] aluRes;
   logic [REGW-1:0]  writeReg;
   logic             branchEq;
   logic             squash;

`ifdef EX_FORWARD_EN
   // Operand forwarding: pick the freshest copy of each source register; 11 falls back to ID/EX.
   always_comb begin
      opA = EX_InReadData1;
      opB = EX_InReadData2;
      case (EX_ForwardA)
         2'b01:   opA = EX_InWBData;
         2'b10:   opA = EXMEM_OutALUResult;
         default: opA = EX_InReadData1;
      endcase
      case (EX_ForwardB)
         2'b01:   opB = EX_InWBData;
         2'b10:   opB = EXMEM_OutALUResult;
         default: opB = EX_InReadData2;
      endcase
   end
`else
   assign opA = EX_InReadData1;
   assign opB = EX_InReadData2;
`endif

   assign aluB     = EX_InALUSrc ? EX_InImm32 : opB;
   assign writeReg = EX_InRegDst ? EX_InRd : EX_InRt;
   assign branchEq = (opA == opB);

   // ALU: add/sub wrap silently, set-less-than results are zero-extended single bits.
   always_comb begin
      aluRes = '0;
      case (EX_InALUCtrl)
         3'b000: aluRes = opA & aluB;
         3'b001: aluRes = opA | aluB;
         3'b010: aluRes = opA + aluB;
         3'b011: aluRes = opA ^ aluB;
         3'b100: aluRes = ~(opA | aluB);
         3'b101: aluRes = {{(WIDTH-1){1'b0}}, (opA < aluB)};
         3'b110: aluRes = opA - aluB;
         3'b111: aluRes = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(aluB))};
      endcase
   end

   // Redirect resolution: jump wins over branch; stalled, flushed or wrong-path slots never redirect.
   always_comb begin
      EX_RedirectPC = EX_InPC + (EX_InImm32 << 2);
      if (EX_InJump)
         EX_RedirectPC = {EX_InPC[WIDTH-1:28], EX_InImm32[25:0], 2'b00};
      EX_Redirect = (EX_InJump | (EX_InBranch & branchEq)) & EXMEM_WriteEn & ~EXMEM_Flush & ~squash;
   end

   // EX/MEM register and wrong-path squash flag: reset > flush > stall > latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         EXMEM_OutALUResult <= '0;
         EXMEM_OutWriteData <= '0;
         EXMEM_OutWriteReg  <= '0;
         EXMEM_OutMemWrite  <= 1'b0;
         EXMEM_OutMemRead   <= 1'b0;
         EXMEM_OutMemtoReg  <= 1'b0;
         EXMEM_OutRegWrite  <= 1'b0;
         EXMEM_OutValid     <= 1'b0;
         squash             <= 1'b0;
      end else if (EXMEM_Flush) begin
         EXMEM_OutALUResult <= '0;
         EXMEM_OutWriteData <= '0;
         EXMEM_OutWriteReg  <= '0;
         EXMEM_OutMemWrite  <= 1'b0;
         EXMEM_OutMemRead   <= 1'b0;
         EXMEM_OutMemtoReg  <= 1'b0;
         EXMEM_OutRegWrite  <= 1'b0;
         EXMEM_OutValid     <= 1'b0;
         squash             <= 1'b0;
      end else if (EXMEM_WriteEn) begin
         // A squashed slot keeps its data but loses every side-effecting control.
         EXMEM_OutALUResult <= aluRes;
         EXMEM_OutWriteData <= opB;
         EXMEM_OutWriteReg  <= squash ? '0 : writeReg;
         EXMEM_OutMemWrite  <= EX_InMemWrite & ~squash;
         EXMEM_OutMemRead   <= EX_InMemRead  & ~squash;
         EXMEM_OutMemtoReg  <= EX_InMemtoReg & ~squash;
         EXMEM_OutRegWrite  <= EX_InRegWrite & ~squash;
         EXMEM_OutValid     <= ~squash;
         squash             <= EX_Redirect;
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed testbench for ex_mem_stage: reset, ALU ops, branch/jump redirect, squash, stall, flush.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit after the next edge.
// Every expected value below is hand-computed from the block's behaviour.
module tb_ex_mem_stage;

   localparam int WIDTH = 32;
   localparam int REGW  = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] EX_InPC, EX_InReadData1, EX_InReadData2, EX_InImm32;
   logic [REGW-1:0]  EX_InRt, EX_InRd;
   logic             EX_InALUSrc, EX_InRegDst, EX_InJump, EX_InBranch;
   logic [2:0]       EX_InALUCtrl;
   logic             EX_InMemWrite, EX_InMemRead, EX_InMemtoReg, EX_InRegWrite;
   logic             EXMEM_WriteEn, EXMEM_Flush;
   logic [WIDTH-1:0] EXMEM_OutALUResult, EXMEM_OutWriteData;
   logic [REGW-1:0]  EXMEM_OutWriteReg;
   logic             EXMEM_OutMemWrite, EXMEM_OutMemRead, EXMEM_OutMemtoReg, EXMEM_OutRegWrite;
   logic             EXMEM_OutValid, EX_Redirect;
   logic [WIDTH-1:0] EX_RedirectPC;
`ifdef EX_FORWARD_EN
   logic [1:0]       EX_ForwardA, EX_ForwardB;
   logic [WIDTH-1:0] EX_InWBData;
`endif

   int nTests = 0;
   int nFail  = 0;

   always #5 clk = ~clk;

   ex_mem_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (
      .clk(clk), .rst(rst),
      .EX_InPC(EX_InPC), .EX_InReadData1(EX_InReadData1), .EX_InReadData2(EX_InReadData2),
      .EX_InImm32(EX_InImm32), .EX_InRt(EX_InRt), .EX_InRd(EX_InRd),
      .EX_InALUSrc(EX_InALUSrc), .EX_InRegDst(EX_InRegDst), .EX_InJump(EX_InJump),
      .EX_InBranch(EX_InBranch), .EX_InALUCtrl(EX_InALUCtrl),
      .EX_InMemWrite(EX_InMemWrite), .EX_InMemRead(EX_InMemRead),
      .EX_InMemtoReg(EX_InMemtoReg), .EX_InRegWrite(EX_InRegWrite),
`ifdef EX_FORWARD_EN
      .EX_ForwardA(EX_ForwardA), .EX_ForwardB(EX_ForwardB), .EX_InWBData(EX_InWBData),
`endif
      .EXMEM_WriteEn(EXMEM_WriteEn), .EXMEM_Flush(EXMEM_Flush),
      .EXMEM_OutALUResult(EXMEM_OutALUResult), .EXMEM_OutWriteData(EXMEM_OutWriteData),
      .EXMEM_OutWriteReg(EXMEM_OutWriteReg), .EXMEM_OutMemWrite(EXMEM_OutMemWrite),
      .EXMEM_OutMemRead(EXMEM_OutMemRead), .EXMEM_OutMemtoReg(EXMEM_OutMemtoReg),
      .EXMEM_OutRegWrite(EXMEM_OutRegWrite), .EXMEM_OutValid(EXMEM_OutValid),
      .EX_Redirect(EX_Redirect), .EX_RedirectPC(EX_RedirectPC)
   );

   // Advance one clock and settle past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Plain enabled no-op: all inputs zero, pipeline enabled.
   task automatic setNop();
      EX_InPC = '0; EX_InReadData1 = '0; EX_InReadData2 = '0; EX_InImm32 = '0;
      EX_InRt = '0; EX_InRd = '0;
      EX_InALUSrc = 0; EX_InRegDst = 0; EX_InJump = 0; EX_InBranch = 0;
      EX_InALUCtrl = 3'b000;
      EX_InMemWrite = 0; EX_InMemRead = 0; EX_InMemtoReg = 0; EX_InRegWrite = 0;
      EXMEM_WriteEn = 1; EXMEM_Flush = 0;
`ifdef EX_FORWARD_EN
      EX_ForwardA = 2'b00; EX_ForwardB = 2'b00; EX_InWBData = '0;
`endif
   endtask

   task automatic test_reset();
      setNop();
      rst = 1;
      EX_InReadData1 = 32'h1; EX_InReadData2 = 32'h2; EX_InImm32 = 32'h33;
      EX_InRt = 5'd7; EX_InRd = 5'd9; EX_InRegDst = 1; EX_InBranch = 1;
      EX_InALUCtrl = 3'b010; EX_InMemWrite = 1; EX_InMemRead = 1;
      EX_InMemtoReg = 1; EX_InRegWrite = 1;
      step(); step();
      nTests++;
      if ({EXMEM_OutALUResult, EXMEM_OutWriteData, EXMEM_OutWriteReg, EXMEM_OutMemWrite,
           EXMEM_OutMemRead, EXMEM_OutMemtoReg, EXMEM_OutRegWrite, EXMEM_OutValid} !== '0) begin
         nFail++;
         $display("FAIL reset_outputs: alu=%h wd=%h wr=%0d mw=%b mr=%b m2r=%b rw=%b v=%b, want all 0",
                  EXMEM_OutALUResult, EXMEM_OutWriteData, EXMEM_OutWriteReg, EXMEM_OutMemWrite,
                  EXMEM_OutMemRead, EXMEM_OutMemtoReg, EXMEM_OutRegWrite, EXMEM_OutValid);
      end
      nTests++;
      if (EX_Redirect !== 1'b0) begin
         nFail++;
         $display("FAIL reset_redirect: got %b want 0", EX_Redirect);
      end
      setNop();
      rst = 0;
      step();
   endtask

   task automatic test_add();
      setNop();
      EX_InReadData1 = 32'h7FFF_FFFF; EX_InReadData2 = 32'h0000_1234; EX_InImm32 = 32'h1;
      EX_InALUSrc = 1; EX_InALUCtrl = 3'b010; EX_InRegDst = 0; EX_InRt = 5'd5; EX_InRd = 5'd9;
      EX_InRegWrite = 1;
      step();
      nTests++;
      if ({EXMEM_OutALUResult, EXMEM_OutWriteReg, EXMEM_OutValid, EXMEM_OutRegWrite}
          !== {32'h8000_0000, 5'd5, 1'b1, 1'b1}) begin
         nFail++;
         $display("FAIL add_wrap: alu=%h wr=%0d v=%b rw=%b, want 80000000 5 1 1",
                  EXMEM_OutALUResult, EXMEM_OutWriteReg, EXMEM_OutValid, EXMEM_OutRegWrite);
      end
      nTests++;
      if (EXMEM_OutWriteData !== 32'h0000_1234) begin
         nFail++;
         $display("FAIL add_writedata: got %h want 00001234", EXMEM_OutWriteData);
      end
      // SUB with RegDst selecting Rd and register operand B.
      setNop();
      EX_InReadData1 = 32'd5; EX_InReadData2 = 32'd7; EX_InImm32 = 32'h100;
      EX_InALUCtrl = 3'b110; EX_InRegDst = 1; EX_InRt = 5'd5; EX_InRd = 5'd9;
      step();
      nTests++;
      if ({EXMEM_OutALUResult, EXMEM_OutWriteReg} !== {32'hFFFF_FFFE, 5'd9}) begin
         nFail++;
         $display("FAIL sub_regdst: alu=%h wr=%0d, want fffffffe 9", EXMEM_OutALUResult, EXMEM_OutWriteReg);
      end
   endtask

   task automatic test_logic_slt();
      logic [2:0]  ops  [6] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b111, 3'b101};
      logic [31:0] as   [6] = '{32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] bs   [6] = '{32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00,
                                32'h0000_0001, 32'h0000_0001};
      logic [31:0] exps [6] = '{32'h00F0_1200, 32'hFFF0_FF34, 32'hFF00_ED34, 32'h000F_00CB,
                                32'h0000_0001, 32'h0000_0000};
      for (int i = 0; i < 6; i++) begin
         setNop();
         EX_InReadData1 = as[i]; EX_InReadData2 = bs[i]; EX_InALUCtrl = ops[i];
         step();
         nTests++;
         if (EXMEM_OutALUResult !== exps[i]) begin
            nFail++;
            $display("FAIL alu_op%b: got %h want %h", ops[i], EXMEM_OutALUResult, exps[i]);
         end
      end
   endtask

   task automatic test_branch();
      // Untaken: operands differ.
      setNop();
      EX_InPC = 32'h100; EX_InReadData1 = 32'd7; EX_InReadData2 = 32'd8;
      EX_InImm32 = 32'hFFFF_FFFE; EX_InBranch = 1;
      #1;
      nTests++;
      if (EX_Redirect !== 1'b0) begin
         nFail++;
         $display("FAIL beq_untaken: redirect=%b want 0", EX_Redirect);
      end
      step();
      // Taken: equal operands; compare ignores ALUSrc.
      EX_InReadData2 = 32'd7; EX_InALUSrc = 1;
      #1;
      nTests++;
      if ({EX_Redirect, EX_RedirectPC} !== {1'b1, 32'h0000_00F8}) begin
         nFail++;
         $display("FAIL beq_taken: redirect=%b pc=%h want 1 000000f8", EX_Redirect, EX_RedirectPC);
      end
      step();
      // Wrong-path instruction: would also be a taken branch but must not redirect.
      setNop();
      EX_InReadData1 = 32'd3; EX_InReadData2 = 32'd3; EX_InBranch = 1;
      EX_InRegWrite = 1; EX_InMemWrite = 1; EX_InRt = 5'd4;
      #1;
      nTests++;
      if (EX_Redirect !== 1'b0) begin
         nFail++;
         $display("FAIL squash_redirect: redirect=%b want 0", EX_Redirect);
      end
      step();
      nTests++;
      if ({EXMEM_OutValid, EXMEM_OutRegWrite, EXMEM_OutMemWrite} !== 3'b000) begin
         nFail++;
         $display("FAIL squash_bubble: v=%b rw=%b mw=%b want 0 0 0",
                  EXMEM_OutValid, EXMEM_OutRegWrite, EXMEM_OutMemWrite);
      end
      // Squash clears after one enabled cycle.
      EX_InBranch = 0;
      step();
      nTests++;
      if ({EXMEM_OutValid, EXMEM_OutRegWrite, EXMEM_OutWriteReg} !== {1'b1, 1'b1, 5'd4}) begin
         nFail++;
         $display("FAIL squash_clear: v=%b rw=%b wr=%0d want 1 1 4",
                  EXMEM_OutValid, EXMEM_OutRegWrite, EXMEM_OutWriteReg);
      end
   endtask

   task automatic test_stall_flush();
      setNop();
      EX_InReadData1 = 32'd1; EX_InReadData2 = 32'd2; EX_InALUCtrl = 3'b010;
      EX_InRt = 5'd3; EX_InRegWrite = 1; EX_InMemWrite = 1;
      step();
      // Stall with a taken branch at the input.
      EXMEM_WriteEn = 0;
      EX_InReadData1 = 32'd9; EX_InReadData2 = 32'd9; EX_InBranch = 1; EX_InRt = 5'd8;
      for (int i = 0; i < 3; i++) begin
         #1;
         nTests++;
         if (EX_Redirect !== 1'b0) begin
            nFail++;
            $display("FAIL stall_redirect%0d: redirect=%b want 0", i, EX_Redirect);
         end
         step();
         nTests++;
         if ({EXMEM_OutALUResult, EXMEM_OutWriteData, EXMEM_OutWriteReg, EXMEM_OutValid, EXMEM_OutMemWrite}
             !== {32'd3, 32'd2, 5'd3, 1'b1, 1'b1}) begin
            nFail++;
            $display("FAIL stall_hold%0d: alu=%h wd=%h wr=%0d v=%b mw=%b want 3 2 3 1 1", i,
                     EXMEM_OutALUResult, EXMEM_OutWriteData, EXMEM_OutWriteReg, EXMEM_OutValid, EXMEM_OutMemWrite);
         end
      end
      // Flush with the same taken branch.
      EXMEM_WriteEn = 1; EXMEM_Flush = 1;
      #1;
      nTests++;
      if (EX_Redirect !== 1'b0) begin
         nFail++;
         $display("FAIL flush_redirect: redirect=%b want 0", EX_Redirect);
      end
      step();
      nTests++;
      if ({EXMEM_OutValid, EXMEM_OutMemWrite, EXMEM_OutRegWrite, EXMEM_OutWriteReg} !== {3'b000, 5'd0}) begin
         nFail++;
         $display("FAIL flush_bubble: v=%b mw=%b rw=%b wr=%0d want 0 0 0 0",
                  EXMEM_OutValid, EXMEM_OutMemWrite, EXMEM_OutRegWrite, EXMEM_OutWriteReg);
      end
      // No redirect occurred, so the next instruction is valid.
      setNop();
      EX_InRegWrite = 1; EX_InRt = 5'd6;
      step();
      nTests++;
      if ({EXMEM_OutValid, EXMEM_OutWriteReg} !== {1'b1, 5'd6}) begin
         nFail++;
         $display("FAIL after_flush: v=%b wr=%0d want 1 6", EXMEM_OutValid, EXMEM_OutWriteReg);
      end
   endtask

   task automatic test_stall_squash();
      // Squash flag must survive a stall and still bubble the next enabled slot.
      setNop();
      EX_InJump = 1; EX_InImm32 = 32'h20;
      step();
      EXMEM_WriteEn = 0;
      step();
      setNop();
      EX_InRegWrite = 1; EX_InRt = 5'd2; EX_InJump = 1;
      #1;
      nTests++;
      if (EX_Redirect !== 1'b0) begin
         nFail++;
         $display("FAIL stall_squash_redirect: redirect=%b want 0", EX_Redirect);
      end
      step();
      nTests++;
      if ({EXMEM_OutValid, EXMEM_OutRegWrite} !== 2'b00) begin
         nFail++;
         $display("FAIL stall_squash_bubble: v=%b rw=%b want 0 0", EXMEM_OutValid, EXMEM_OutRegWrite);
      end
      setNop();
      step();
   endtask

   task automatic test_jump_branch();
      setNop();
      EX_InPC = 32'h4000_0010; EX_InImm32 = 32'h10; EX_InJump = 1; EX_InBranch = 1;
      EX_InReadData1 = 32'd5; EX_InReadData2 = 32'd5;
      #1;
      nTests++;
      if ({EX_Redirect, EX_RedirectPC} !== {1'b1, 32'h4000_0040}) begin
         nFail++;
         $display("FAIL jump_priority: redirect=%b pc=%h want 1 40000040", EX_Redirect, EX_RedirectPC);
      end
      step();
      setNop();
      step();
   endtask

   task automatic test_reset_mid_redirect();
      setNop();
      EX_InJump = 1; EX_InImm32 = 32'h44;
      rst = 1;
      step();
      rst = 0;
      setNop();
      EX_InRegWrite = 1; EX_InRt = 5'd11;
      step();
      nTests++;
      if ({EXMEM_OutValid, EXMEM_OutRegWrite, EXMEM_OutWriteReg} !== {1'b1, 1'b1, 5'd11}) begin
         nFail++;
         $display("FAIL reset_clears_squash: v=%b rw=%b wr=%0d want 1 1 11",
                  EXMEM_OutValid, EXMEM_OutRegWrite, EXMEM_OutWriteReg);
      end
   endtask

`ifdef EX_FORWARD_EN
   task automatic test_forward();
      setNop();
      EX_InReadData1 = 32'd5; EX_InReadData2 = 32'd3; EX_InALUCtrl = 3'b010;
      EX_ForwardA = 2'b01; EX_InWBData = 32'h100;
      step();
      nTests++;
      if (EXMEM_OutALUResult !== 32'h103) begin
         nFail++;
         $display("FAIL fwd_wb: got %h want 00000103", EXMEM_OutALUResult);
      end
      setNop();
      EX_InReadData1 = 32'd1; EX_InReadData2 = 32'd7; EX_InALUCtrl = 3'b010;
      EX_ForwardB = 2'b10;
      step();
      nTests++;
      if ({EXMEM_OutALUResult, EXMEM_OutWriteData} !== {32'h104, 32'h103}) begin
         nFail++;
         $display("FAIL fwd_exmem: alu=%h wd=%h want 00000104 00000103", EXMEM_OutALUResult, EXMEM_OutWriteData);
      end
   endtask
`endif

   initial begin
      rst = 1;
      setNop();
      test_reset();
      test_add();
      test_logic_slt();
      test_branch();
      test_stall_flush();
      test_stall_squash();
      test_jump_branch();
      test_reset_mid_redirect();
`ifdef EX_FORWARD_EN
      test_forward();
`endif
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
